// File: rtl/argmax_fp16_seq.sv
// Sequential fp16 argmax: snapshots N_CLASSES scores on start, then scans
// one entry per cycle and reports the winning index, its raw bits, and
// whether any NaN was present. The snapshot frees the upstream datapath
// as soon as the scan begins.
module argmax_fp16_seq #(
    parameter int N_CLASSES = 10,
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [N_CLASSES-1:0][WIDTH-1:0]     scores,
    output logic                                busy,
    output logic                                done,
    output logic [IDX_WIDTH-1:0]                digit,
    output logic [WIDTH-1:0]                    max_val,
    output logic                                nan_seen
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_CLASSES - 1);

    // NaN: all-ones exponent with a non-zero mantissa.
    function automatic logic is_nan(input logic [WIDTH-1:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

    // Ranking key: negatives (including -0) and NaN collapse to zero so they
    // tie with +0; otherwise the magnitude bits order correctly as unsigned.
    function automatic logic [14:0] rank_key(input logic [WIDTH-1:0] v);
        logic [14:0] k;
        if (v[15] || is_nan(v)) begin
            k = 15'h0000;
        end else begin
            k = v[14:0];
        end
        return k;
    endfunction

    state_t                             state_q, state_d;
    logic [N_CLASSES-1:0][WIDTH-1:0]    snap_q, snap_d;
    logic [IDX_WIDTH-1:0]               idx_q, idx_d;
    logic [14:0]                        best_key_q, best_key_d;
    logic [IDX_WIDTH-1:0]               best_idx_q, best_idx_d;
    logic [WIDTH-1:0]                   best_raw_q, best_raw_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic [IDX_WIDTH-1:0]               digit_q, digit_d;
    logic [WIDTH-1:0]                   max_val_q, max_val_d;
    logic                               nan_q, nan_d;

    logic [WIDTH-1:0]                   cur_raw_s;
    logic                               take_s;

    // Next-state and datapath updates for the IDLE -> SCAN -> DONE sequence.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        best_key_d = best_key_q;
        best_idx_d = best_idx_q;
        best_raw_d = best_raw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        digit_d    = digit_q;
        max_val_d  = max_val_q;
        nan_d      = nan_q;

        cur_raw_s  = snap_q[idx_q];
        take_s     = (rank_key(cur_raw_s) > best_key_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d     = scores;
                    best_key_d = rank_key(scores[0]);
                    best_idx_d = '0;
                    best_raw_d = scores[0];
                    nan_d      = is_nan(scores[0]);
                    idx_d      = IDX_WIDTH'(1);
                    busy_d     = 1'b1;
                    state_d    = ST_SCAN;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (take_s) begin
                    best_key_d = rank_key(cur_raw_s);
                    best_idx_d = idx_q;
                    best_raw_d = cur_raw_s;
                end else begin
                    best_key_d = best_key_q;
                end
                nan_d = nan_q | is_nan(cur_raw_s);
                if (idx_q == LAST_IDX) begin
                    // Publish the final winner, including the last entry.
                    digit_d   = take_s ? idx_q : best_idx_q;
                    max_val_d = take_s ? cur_raw_s : best_raw_q;
                    done_d    = 1'b1;
                    idx_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    idx_d     = idx_q + IDX_WIDTH'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any scan without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            best_key_q <= 15'h0000;
            best_idx_q <= '0;
            best_raw_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            digit_q    <= '0;
            max_val_q  <= '0;
            nan_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            best_key_q <= best_key_d;
            best_idx_q <= best_idx_d;
            best_raw_q <= best_raw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            digit_q    <= digit_d;
            max_val_q  <= max_val_d;
            nan_q      <= nan_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digit    = digit_q;
    assign max_val  = max_val_q;
    assign nan_seen = nan_q;

endmodule

// File: tb/tb_argmax_fp16_seq.sv
// Testbench for argmax_fp16_seq: directed and randomized scans checked
// against a real-valued argmax reference model.
module tb_argmax_fp16_seq;

    typedef logic [9:0][15:0] scores_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    scores_t     scores = '0;
    logic        busy, done, nan_seen;
    logic [3:0]  digit;
    logic [15:0] max_val;

    int checks = 0;
    int errors = 0;
    logic [3:0]  prev_digit = 4'd0;
    logic [15:0] prev_max   = 16'h0000;

    argmax_fp16_seq #(.N_CLASSES(10), .WIDTH(16), .IDX_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .scores(scores),
        .busy(busy), .done(done), .digit(digit), .max_val(max_val),
        .nan_seen(nan_seen)
    );

    always #5 clk = ~clk;

    function automatic bit fp_is_nan(input logic [15:0] v);
        return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
    endfunction

    // Numeric value used for ranking: negatives and NaN count as zero.
    function automatic real fp_rank(input logic [15:0] v);
        int e;
        int m;
        e = int'(v[14:10]);
        m = int'(v[9:0]);
        if (v[15] || fp_is_nan(v)) return 0.0;
        if (e == 31) return 1.0e30;
        if (e == 0) return real'(m) * (2.0 ** (-24));
        return (1024.0 + real'(m)) * (2.0 ** (e - 25));
    endfunction

    // Reference argmax: first index with the largest rank value.
    task automatic model(input scores_t s, output logic [3:0] d,
                         output logic [15:0] mv, output bit nan);
        real best;
        d    = 4'd0;
        best = fp_rank(s[0]);
        nan  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (fp_rank(s[i]) > best) begin
                best = fp_rank(s[i]);
                d    = 4'(i);
            end
            if (fp_is_nan(s[i])) nan = 1'b1;
        end
        mv = s[d];
    endtask

    function automatic scores_t rand_scores();
        scores_t s;
        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 11))
                0:       s[i] = 16'h0000;
                1:       s[i] = {1'b1, 15'($urandom)};
                2:       s[i] = {1'b0, 5'h1F, 10'($urandom_range(1, 1023))};
                3:       s[i] = 16'h7C00;
                4:       s[i] = {6'b000000, 10'($urandom)};
                5:       s[i] = (i > 0) ? s[i-1] : 16'h3C00;
                default: s[i] = {1'b0, 5'($urandom_range(0, 30)), 10'($urandom)};
            endcase
        end
        return s;
    endfunction

    // One scan, called at a negedge. exp_wait is the number of edges until
    // start is sampled (2 when issued in the DONE cycle).
    task automatic do_scan(input scores_t s, input string name, input bit mid_start,
                           input bit change_after, input int exp_wait, input bit check_tail);
        logic [3:0]  ed;
        logic [15:0] em;
        bit          en;
        int          waited;
        bit          seen;
        model(s, ed, em, en);
        scores = s;
        start  = 1'b1;
        waited = 0;
        seen   = 1'b0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!busy && waited < 4);
        checks++;
        if (busy !== 1'b1 || waited != exp_wait) begin
            errors++;
            $display("FAIL %s/start_sample: busy=%0b edges=%0d, want busy=1 edges=%0d",
                     name, busy, waited, exp_wait);
        end
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (change_after && c == 2) scores = rand_scores();
            if (mid_start) start = (c == 3);
            if (done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (c != 10) begin
                    errors++;
                    $display("FAIL %s/latency: done in cycle %0d, want 10", name, c);
                end
                checks++;
                if (digit !== ed) begin
                    errors++;
                    $display("FAIL %s/digit: got %0d want %0d", name, digit, ed);
                end
                checks++;
                if (max_val !== em) begin
                    errors++;
                    $display("FAIL %s/max_val: got %h want %h", name, max_val, em);
                end
                checks++;
                if (nan_seen !== en) begin
                    errors++;
                    $display("FAIL %s/nan_seen: got %0b want %0b", name, nan_seen, en);
                end
                break;
            end else if (c <= 9) begin
                checks++;
                if (digit !== prev_digit || max_val !== prev_max || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s/hold_c%0d: digit=%0d max=%h busy=%0b, want digit=%0d max=%h busy=1",
                             name, c, digit, max_val, busy, prev_digit, prev_max);
                end
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s/timeout: done=0 after 14 cycles, want done in cycle 10", name);
        end
        prev_digit = ed;
        prev_max   = em;
        if (check_tail) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s/tail: done=%0b busy=%0b, want 0 0", name, done, busy);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, digit, max_val, nan_seen} !== 23'h0) begin
            errors++;
            $display("FAIL reset/outputs: got busy=%0b done=%0b digit=%0d max=%h nan=%0b, want all 0",
                     busy, done, digit, max_val, nan_seen);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        scores_t s;
        s = '0;
        do_scan(s, "all_zero", 1'b0, 1'b0, 1, 1'b1);
        for (int i = 0; i < 10; i++) s[i] = 16'h3800;
        s[7] = 16'h4000;
        s[3] = 16'h3C00;
        do_scan(s, "max_2p0", 1'b0, 1'b0, 1, 1'b1);
        s = '0;
        s[2] = 16'h4500;
        s[8] = 16'h4500;
        do_scan(s, "tie", 1'b0, 1'b0, 1, 1'b1);
        for (int i = 0; i < 10; i++) s[i] = {1'b0, 5'($urandom_range(0, 30)), 10'($urandom)};
        s[9] = 16'h7C00;
        do_scan(s, "inf", 1'b0, 1'b0, 1, 1'b1);
        s = '0;
        s[0] = 16'hBC00;
        s[1] = 16'h8000;
        s[5] = 16'h7E00;
        s[6] = 16'h0001;
        do_scan(s, "neg_nan_sub", 1'b0, 1'b0, 1, 1'b1);
        s = '0;
        s[0] = 16'hBC00;
        s[4] = 16'h7E01;
        do_scan(s, "all_key0", 1'b0, 1'b0, 1, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) do_scan(rand_scores(), "random", 1'b0, 1'b0, 1, 1'b1);
    endtask

    task automatic test_busy_start_and_snapshot();
        scores_t s;
        s = rand_scores();
        do_scan(s, "mid_start", 1'b1, 1'b1, 1, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_scan(rand_scores(), "b2b_first", 1'b0, 1'b0, 1, 1'b0);
        do_scan(rand_scores(), "b2b_second", 1'b0, 1'b0, 2, 1'b0);
        do_scan(rand_scores(), "b2b_third", 1'b0, 1'b0, 2, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        scores_t s;
        int      dones;
        s = '0;
        s[0] = 16'h7E00;
        s[4] = 16'h4400;
        scores = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, digit, max_val, nan_seen} !== 23'h0) begin
            errors++;
            $display("FAIL rst_mid/outputs: got busy=%0b done=%0b digit=%0d max=%h nan=%0b, want all 0",
                     busy, done, digit, max_val, nan_seen);
        end
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL rst_mid/no_done: %0d cycles with done/busy high, want 0", dones);
        end
        prev_digit = 4'd0;
        prev_max   = 16'h0000;
        do_scan(rand_scores(), "after_rst", 1'b0, 1'b0, 1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_start_and_snapshot();
        test_back_to_back();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
